button_debouncer: RTL

- Input-side counterpart to the LED output path. Turns the raw low-active board push-button into clean, single-cycle events in the clk domain.
- Synchronizes and debounces the pin, then emits press, release and long-press ticks plus a wrapping press counter.
- Drives LED/counter logic in place of free-running timers; sits beside the reset generator on the 24 MHz clk.

---
 rtl/button_debouncer_pkg.sv | 14 +
 rtl/button_debouncer_sync_2ff.sv | 26 ++
 rtl/button_debouncer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared clock-rate constants and time-to-cycle helpers for the push-button input path.
package button_debouncer_pkg;

    localparam int unsigned CLK_HZ = 24_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    // 10 ms settle window and 1 s hold threshold at the system clock rate.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT  = ms_to_cycles(10);
    localparam int unsigned LONGPRESS_CYCLES_DEFAULT = ms_to_cycles(1000);

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// Debounces the low-active push-button into press/release/long-press ticks and a wrapping press count.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DebounceCycles  = int'(DEBOUNCE_CYCLES_DEFAULT),
    parameter int LongPressCycles = int'(LONGPRESS_CYCLES_DEFAULT),
    parameter int CntSize         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnx,
    output logic       pressed,
    output logic       press_tick,
    output logic       release_tick,
    output logic       long_tick,
    output logic [7:0] press_count
);

    if (DebounceCycles < 2 || LongPressCycles <= DebounceCycles ||
        longint'(LongPressCycles) > (longint'(1) << CntSize)) begin : g_param_err
        $error("button_debouncer: bad DebounceCycles/LongPressCycles/CntSize");
    end

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    localparam logic [CntSize-1:0] DEB_LAST  = CntSize'(DebounceCycles - 1);
    localparam logic [CntSize-1:0] LONG_LAST = CntSize'(LongPressCycles - 1);
    localparam logic [CntSize-1:0] CNT_ONE   = CntSize'(1);

    logic w_btn_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (btnx),
        .o_q   (w_btn_s)
    );

    state_t             r_state,        w_state_nxt;
    logic [CntSize-1:0] r_deb_cnt,      w_deb_cnt_nxt;
    logic [CntSize-1:0] r_hold_cnt,     w_hold_cnt_nxt;
    logic               r_long_done,    w_long_done_nxt;
    logic               r_press_tick,   w_press_tick_nxt;
    logic               r_release_tick, w_release_tick_nxt;
    logic               r_long_tick,    w_long_tick_nxt;
    logic               r_pressed,      w_pressed_nxt;
    logic [7:0]         r_press_count,  w_press_count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RELEASED;
            r_deb_cnt      <= '0;
            r_hold_cnt     <= '0;
            r_long_done    <= 1'b0;
            r_press_tick   <= 1'b0;
            r_release_tick <= 1'b0;
            r_long_tick    <= 1'b0;
            r_pressed      <= 1'b0;
            r_press_count  <= 8'h00;
        end else begin
            r_state        <= w_state_nxt;
            r_deb_cnt      <= w_deb_cnt_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_long_done    <= w_long_done_nxt;
            r_press_tick   <= w_press_tick_nxt;
            r_release_tick <= w_release_tick_nxt;
            r_long_tick    <= w_long_tick_nxt;
            r_pressed      <= w_pressed_nxt;
            r_press_count  <= w_press_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_deb_cnt_nxt      = r_deb_cnt;
        w_hold_cnt_nxt     = r_hold_cnt;
        w_long_done_nxt    = r_long_done;
        w_press_tick_nxt   = 1'b0;
        w_release_tick_nxt = 1'b0;
        w_long_tick_nxt    = 1'b0;
        w_press_count_nxt  = r_press_count;

        // Hold timer runs through release bounces so a wobbly release cannot restart it.
        if ((r_state == ST_PRESSED || r_state == ST_RELEASE_WAIT) && !r_long_done) begin
            if (r_hold_cnt == LONG_LAST) begin
                w_long_tick_nxt = 1'b1;
                w_long_done_nxt = 1'b1;
            end else begin
                w_hold_cnt_nxt = r_hold_cnt + CNT_ONE;
            end
        end

        case (r_state)
            ST_RELEASED: begin
                if (!w_btn_s) begin
                    w_state_nxt   = ST_PRESS_WAIT;
                    w_deb_cnt_nxt = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (w_btn_s) begin
                    w_state_nxt   = ST_RELEASED;
                    w_deb_cnt_nxt = '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt       = ST_PRESSED;
                    w_press_tick_nxt  = 1'b1;
                    w_press_count_nxt = r_press_count + 8'd1;
                    w_hold_cnt_nxt    = '0;
                    w_long_done_nxt   = 1'b0;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (w_btn_s) begin
                    w_state_nxt   = ST_RELEASE_WAIT;
                    w_deb_cnt_nxt = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nxt = ST_PRESSED;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt        = ST_RELEASED;
                    w_release_tick_nxt = 1'b1;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + CNT_ONE;
                end
            end
            default: w_state_nxt = ST_RELEASED;
        endcase

        w_pressed_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
    end

    assign pressed      = r_pressed;
    assign press_tick   = r_press_tick;
    assign release_tick = r_release_tick;
    assign long_tick    = r_long_tick;
    assign press_count  = r_press_count;

endmodule
